// File: rtl/id_bypass_scoreboard_if.sv
// Decode-stage hazard/bypass scoreboard signal bundle: ID-side request inputs
// and the operand-mux select / stall results.
interface id_bypass_scoreboard_if #(
    parameter int unsigned AW   = 5,
    parameter int unsigned LW   = 2,
    parameter int unsigned SELW = 3
);
    logic [AW-1:0]   id_rs;
    logic [AW-1:0]   id_rt;
    logic            id_rs_rd;
    logic            id_rt_rd;
    logic            id_wr_en;
    logic [AW-1:0]   id_dst;
    logic [LW-1:0]   id_lat;
    logic            id_issue;
    logic            pipe_adv;
    logic            flush;
    logic [SELW-1:0] fwd_sel_a;
    logic [SELW-1:0] fwd_sel_b;
    logic            stall;
    logic [SELW-1:0] stall_slot;
    logic [31:0]     stall_cnt;

    modport master (
        output id_rs, id_rt, id_rs_rd, id_rt_rd, id_wr_en, id_dst, id_lat,
               id_issue, pipe_adv, flush,
        input  fwd_sel_a, fwd_sel_b, stall, stall_slot, stall_cnt
    );

    modport slave (
        input  id_rs, id_rt, id_rs_rd, id_rt_rd, id_wr_en, id_dst, id_lat,
               id_issue, pipe_adv, flush,
        output fwd_sel_a, fwd_sel_b, stall, stall_slot, stall_cnt
    );
endinterface

// File: rtl/id_bypass_scoreboard.sv
// ID-stage writer shadow pipeline producing per-operand bypass selects and the load-use stall.
// Optional stall-cycle counter enabled by defining ID_SB_STALL_CNT_EN.
module id_bypass_scoreboard #(
    parameter int unsigned NSTAGE = 4,
    parameter int unsigned AW     = 5,
    parameter int unsigned LW     = 2,
    parameter int unsigned SELW   = 3
) (
    input logic               clk,
    input logic               resetn,
    id_bypass_scoreboard_if.slave sb
);
    localparam int unsigned FLUSH_SLOTS = 2;

    typedef struct packed {
        logic          v;
        logic [AW-1:0] dst;
        logic [LW-1:0] lat;
    } slot_t;

    slot_t slot_q  [NSTAGE];
    slot_t slot_sq [NSTAGE];
    slot_t slot_d  [NSTAGE];

    logic [AW-1:0]   src  [2];
    logic            rd   [2];
    logic [SELW-1:0] sel  [2];
    logic [SELW-1:0] pos  [2];
    logic            stl  [2];
    logic            found;

    // Squash is applied before the shift so flushed entries travel on as bubbles.
    always_comb begin
        for (int unsigned i = 0; i < NSTAGE; i++) begin
            slot_sq[i] = slot_q[i];
            if (sb.flush && i < FLUSH_SLOTS) slot_sq[i].v = 1'b0;
        end
        for (int unsigned i = 0; i < NSTAGE; i++) slot_d[i] = slot_sq[i];
        if (sb.pipe_adv) begin
            slot_d[0] = '0;
            if (sb.id_issue && sb.id_wr_en && sb.id_dst != '0 && !sb.flush) begin
                slot_d[0].v   = 1'b1;
                slot_d[0].dst = sb.id_dst;
                slot_d[0].lat = sb.id_lat;
            end
            for (int unsigned i = 1; i < NSTAGE; i++) slot_d[i] = slot_sq[i-1];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < NSTAGE; i++) slot_q[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NSTAGE; i++) slot_q[i] <= slot_d[i];
        end
    end

    // Scan upward and keep only the first hit so the youngest writer wins.
    always_comb begin
        src[0] = sb.id_rs;
        src[1] = sb.id_rt;
        rd[0]  = sb.id_rs_rd;
        rd[1]  = sb.id_rt_rd;
        found  = 1'b0;
        for (int unsigned op = 0; op < 2; op++) begin
            sel[op] = '0;
            pos[op] = '0;
            stl[op] = 1'b0;
            found   = 1'b0;
            for (int unsigned j = 0; j < NSTAGE; j++) begin
                if (!found && slot_q[j].v && slot_q[j].dst == src[op] &&
                    src[op] != '0 && rd[op]) begin
                    found   = 1'b1;
                    pos[op] = SELW'(j + 1);
                    if (j >= 32'(slot_q[j].lat)) sel[op] = SELW'(j + 1);
                    else                         stl[op] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        sb.fwd_sel_a  = sel[0];
        sb.fwd_sel_b  = sel[1];
        sb.stall      = stl[0] | stl[1];
        sb.stall_slot = '0;
        if (stl[0] && stl[1])  sb.stall_slot = (pos[0] < pos[1]) ? pos[0] : pos[1];
        else if (stl[0])       sb.stall_slot = pos[0];
        else if (stl[1])       sb.stall_slot = pos[1];
    end

`ifdef ID_SB_STALL_CNT_EN
    logic [31:0] cnt_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else if (sb.stall && cnt_q != '1) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    always_comb sb.stall_cnt = cnt_q;
`else
    always_comb sb.stall_cnt = '0;
`endif

endmodule

// File: tb/tb_id_bypass_scoreboard.sv
// Directed scoreboard bench for id_bypass_scoreboard: expected selects/stalls
// are queued as each ID cycle is driven and compared mid-cycle.
module tb_id_bypass_scoreboard;

`ifdef ID_SB_STALL_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    typedef struct {
        logic [2:0] a;
        logic [2:0] b;
        logic       s;
        logic [2:0] sl;
    } exp_t;

    logic clk    = 1'b0;
    logic resetn = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [31:0] cnt_exp = '0;
    exp_t exp_q [$];

    id_bypass_scoreboard_if #(.AW(5), .LW(2), .SELW(3)) sb_if ();

    id_bypass_scoreboard #(.NSTAGE(4), .AW(5), .LW(2), .SELW(3)) dut (
        .clk    (clk),
        .resetn (resetn),
        .sb     (sb_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One ID cycle: drive, queue expectation, compare mid-cycle, then clock.
    task automatic cyc(input logic [4:0] rs, input logic rsrd, input logic [4:0] rt,
                       input logic rtrd, input logic issue, input logic [4:0] dst,
                       input logic [1:0] lat, input logic adv, input logic fl,
                       input logic [2:0] ea, input logic [2:0] eb, input logic es,
                       input logic [2:0] eslot);
        exp_t e;
        sb_if.id_rs    = rs;
        sb_if.id_rs_rd = rsrd;
        sb_if.id_rt    = rt;
        sb_if.id_rt_rd = rtrd;
        sb_if.id_issue = issue;
        sb_if.id_wr_en = issue;
        sb_if.id_dst   = dst;
        sb_if.id_lat   = lat;
        sb_if.pipe_adv = adv;
        sb_if.flush    = fl;
        e.a = ea; e.b = eb; e.s = es; e.sl = eslot;
        exp_q.push_back(e);
        #4;
        e = exp_q.pop_front();
        check("fwd_sel_a",  32'(sb_if.fwd_sel_a),  32'(e.a));
        check("fwd_sel_b",  32'(sb_if.fwd_sel_b),  32'(e.b));
        check("stall",      32'(sb_if.stall),      32'(e.s));
        check("stall_slot", 32'(sb_if.stall_slot), 32'(e.sl));
        check("stall_cnt",  sb_if.stall_cnt,       cnt_exp);
        if (CNT_EN && e.s) cnt_exp++;
        @(posedge clk);
        #1;
    endtask

    task automatic iss(input logic [4:0] dst, input logic [1:0] lat);
        cyc(5'd0, 1'b0, 5'd0, 1'b0, 1'b1, dst, lat, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            cyc(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 2'd0, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0);
    endtask

    task automatic rd(input logic [4:0] rs, input logic [4:0] rt, input logic adv,
                      input logic [2:0] ea, input logic [2:0] eb, input logic es,
                      input logic [2:0] eslot);
        cyc(rs, 1'b1, rt, 1'b1, 1'b0, 5'd0, 2'd0, adv, 1'b0, ea, eb, es, eslot);
    endtask

    initial begin
        sb_if.id_rs = '0;    sb_if.id_rt = '0;    sb_if.id_rs_rd = 1'b0;
        sb_if.id_rt_rd = 1'b0; sb_if.id_wr_en = 1'b0; sb_if.id_dst = '0;
        sb_if.id_lat = '0;   sb_if.id_issue = 1'b0; sb_if.pipe_adv = 1'b0;
        sb_if.flush = 1'b0;
        #1 resetn = 1'b0;
        #3;
        check("rst_sel_a",  32'(sb_if.fwd_sel_a),  32'd0);
        check("rst_sel_b",  32'(sb_if.fwd_sel_b),  32'd0);
        check("rst_stall",  32'(sb_if.stall),      32'd0);
        check("rst_slot",   32'(sb_if.stall_slot), 32'd0);
        check("rst_cnt",    sb_if.stall_cnt,       32'd0);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;

        // ALU RAW
        iss(5'd5, 2'd0);
        rd(5'd5, 5'd0, 1'b1, 3'd1, 3'd0, 1'b0, 3'd0);
        rd(5'd5, 5'd0, 1'b1, 3'd2, 3'd0, 1'b0, 3'd0);
        idle(4);

        // Load-use
        iss(5'd8, 2'd2);
        rd(5'd0, 5'd8, 1'b1, 3'd0, 3'd0, 1'b1, 3'd1);
        rd(5'd0, 5'd8, 1'b1, 3'd0, 3'd0, 1'b1, 3'd2);
        rd(5'd0, 5'd8, 1'b1, 3'd0, 3'd3, 1'b0, 3'd0);
        idle(4);

        // Two loads: stall_slot is the youngest blocking slot; lat=3 boundary
        iss(5'd8, 2'd2);
        iss(5'd9, 2'd3);
        rd(5'd8, 5'd9, 1'b1, 3'd0, 3'd0, 1'b1, 3'd1);
        rd(5'd8, 5'd9, 1'b1, 3'd3, 3'd0, 1'b1, 3'd2);
        rd(5'd8, 5'd9, 1'b1, 3'd4, 3'd0, 1'b1, 3'd3);
        rd(5'd8, 5'd9, 1'b1, 3'd0, 3'd4, 1'b0, 3'd0);
        idle(4);

        // Youngest wins, then freeze with issue held high
        iss(5'd3, 2'd0);
        idle(1);
        iss(5'd3, 2'd0);
        rd(5'd3, 5'd3, 1'b0, 3'd1, 3'd1, 1'b0, 3'd0);
        for (int i = 0; i < 3; i++)
            cyc(5'd7, 1'b1, 5'd3, 1'b1, 1'b1, 5'd7, 2'd0, 1'b0, 1'b0, 3'd0, 3'd1, 1'b0, 3'd0);
        rd(5'd0, 5'd3, 1'b0, 3'd0, 3'd1, 1'b0, 3'd0);
        rd(5'd7, 5'd3, 1'b1, 3'd0, 3'd1, 1'b0, 3'd0);
        rd(5'd7, 5'd3, 1'b1, 3'd0, 3'd2, 1'b0, 3'd0);
        idle(4);

        // Flush with all slots valid; flush beats a concurrent issue
        iss(5'd10, 2'd0);
        iss(5'd11, 2'd0);
        iss(5'd12, 2'd0);
        iss(5'd13, 2'd0);
        cyc(5'd13, 1'b1, 5'd10, 1'b1, 1'b1, 5'd20, 2'd0, 1'b1, 1'b1, 3'd1, 3'd4, 1'b0, 3'd0);
        rd(5'd20, 5'd11, 1'b1, 3'd0, 3'd4, 1'b0, 3'd0);
        rd(5'd13, 5'd12, 1'b1, 3'd0, 3'd0, 1'b0, 3'd0);
        rd(5'd10, 5'd11, 1'b1, 3'd0, 3'd0, 1'b0, 3'd0);
        idle(2);

        // Async reset in the middle of a stall
        iss(5'd8, 2'd2);
        sb_if.id_rs = '0; sb_if.id_rs_rd = 1'b0;
        sb_if.id_rt = 5'd8; sb_if.id_rt_rd = 1'b1;
        sb_if.id_issue = 1'b0; sb_if.id_wr_en = 1'b0;
        #3;
        check("pre_rst_stall", 32'(sb_if.stall),      32'd1);
        check("pre_rst_slot",  32'(sb_if.stall_slot), 32'd1);
        check("pre_rst_cnt",   sb_if.stall_cnt,       cnt_exp);
        resetn = 1'b0;
        #1;
        cnt_exp = '0;
        check("arst_sel_b",  32'(sb_if.fwd_sel_b),  32'd0);
        check("arst_stall",  32'(sb_if.stall),      32'd0);
        check("arst_slot",   32'(sb_if.stall_slot), 32'd0);
        check("arst_cnt",    sb_if.stall_cnt,       32'd0);
        #1 resetn = 1'b1;
        @(posedge clk);
        #1;

        // Five stall cycles (three frozen, two advancing) then forward
        iss(5'd9, 2'd2);
        for (int i = 0; i < 3; i++) rd(5'd0, 5'd9, 1'b0, 3'd0, 3'd0, 1'b1, 3'd1);
        rd(5'd0, 5'd9, 1'b1, 3'd0, 3'd0, 1'b1, 3'd1);
        rd(5'd0, 5'd9, 1'b1, 3'd0, 3'd0, 1'b1, 3'd2);
        rd(5'd0, 5'd9, 1'b1, 3'd0, 3'd3, 1'b0, 3'd0);
        check("stall_cnt_total", sb_if.stall_cnt, CNT_EN ? 32'd5 : 32'd0);
        idle(2);

        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d expected 0 pending", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got %0t expected < 100000", $time);
        $fatal(1, "bench timeout");
    end

endmodule
